dmem_port_arbiter: RTL and testbench

//  Shares the single-port 64-bit data SRAM between two requesters: the pipeline MEM stage (cpu_*) and the external host port (host_*).

---
 rtl/dmem_port_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data SRAM between the MEM stage
// (cpu_*) and the external host port (host_*). The CPU wins ties unless the
// host has been denied STARVE_LIM cycles in a row. Read data is routed back
// one cycle later to whichever side issued the read.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  logic [CNT_W-1:0] starve_cnt;
  owner_e           rd_owner;
  logic             starved;
  logic             host_win;

  // Host takes the port when alone, or when it has waited the full limit.
  always_comb begin
    starved   = (starve_cnt == CNT_W'(STARVE_LIM));
    host_win  = host_req & (~cpu_req | starved);
    host_gnt  = host_win;
    cpu_gnt   = cpu_req & ~host_win;
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // SRAM drive muxed from the granted requester; quiet bus when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wen   = host_wen;
      mem_ren   = ~host_wen;
    end
  end

  // Starvation counter and read-owner tracking for the one-cycle return.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (host_req & ~host_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
      if (cpu_gnt & ~cpu_wen)        rd_owner <= OWN_CPU;
      else if (host_gnt & ~host_wen) rd_owner <= OWN_HOST;
      else                           rd_owner <= OWN_NONE;
    end
  end

  // Return path: SRAM data lands the cycle after mem_ren, steered by owner.
  // Masked by rst so a read in flight when reset hits never reports valid.
  always_comb begin
    cpu_rvalid  = (rd_owner == OWN_CPU)  & ~rst;
    host_rvalid = (rd_owner == OWN_HOST) & ~rst;
    cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: grant priority, starvation override,
// SRAM drive and one-cycle read return routing.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_wen, host_req, host_wen;
  logic [ADDR_W-1:0] cpu_addr, host_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic              mem_wen, mem_ren;
  logic [DATA_W-1:0] cpu_rdata, host_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_wen = 0; host_addr = '0; host_wdata = '0;
  endtask

  // both sides reading: cpu must win n cycles, then host is forced through
  task automatic contend(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_cpu_gnt"}, 64'(cpu_gnt), 64'd1);
      chk({tag, "_host_gnt"}, 64'(host_gnt), 64'd0);
      cyc();
    end
    @(negedge clk);
    chk({tag, "_forced_host_gnt"}, 64'(host_gnt), 64'd1);
    chk({tag, "_forced_cpu_gnt"}, 64'(cpu_gnt), 64'd0);
    chk({tag, "_forced_stall"}, 64'(cpu_stall), 64'd1);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    cyc(); cyc();

    // reset state
    @(negedge clk);
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_host_rdata", host_rdata, 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: lone cpu read
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h10;
    @(negedge clk);
    chk("t1_cpu_gnt", 64'(cpu_gnt), 64'd1);
    chk("t1_mem_ren", 64'(mem_ren), 64'd1);
    chk("t1_mem_wen", 64'(mem_wen), 64'd0);
    chk("t1_mem_addr", mem_addr, 64'h10);
    chk("t1_stall", 64'(cpu_stall), 64'd0);
    cyc();
    idle(); mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("t1_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t1_cpu_rdata", cpu_rdata, 64'h1111_2222_3333_4444);
    chk("t1_host_rvalid", 64'(host_rvalid), 64'd0);
    chk("t1_host_rdata", host_rdata, 64'd0);
    chk("t1_idle_mem_addr", mem_addr, 64'd0);
    cyc();

    // 2: continuous contention
    cpu_req = 1; cpu_addr = 64'h20; host_req = 1; host_addr = 64'h30;
    contend(4, "t2");
    chk("t2_host_addr", mem_addr, 64'h30);
    chk("t2_host_ren", 64'(mem_ren), 64'd1);
    cyc();
    mem_rdata = 64'h5555_6666;
    @(negedge clk);
    chk("t2_cpu_again", 64'(cpu_gnt), 64'd1);
    chk("t2_host_rvalid", 64'(host_rvalid), 64'd1);
    chk("t2_host_rdata", host_rdata, 64'h5555_6666);
    chk("t2_cpu_rdata_zero", cpu_rdata, 64'd0);
    cyc();
    idle(); cyc();

    // 3: host write, cpu idle
    host_req = 1; host_wen = 1; host_addr = 64'h8; host_wdata = 64'hDEAD;
    @(negedge clk);
    chk("t3_host_gnt", 64'(host_gnt), 64'd1);
    chk("t3_mem_wen", 64'(mem_wen), 64'd1);
    chk("t3_mem_ren", 64'(mem_ren), 64'd0);
    chk("t3_mem_wdata", mem_wdata, 64'hDEAD);
    chk("t3_mem_addr", mem_addr, 64'h8);
    cyc();
    idle();
    @(negedge clk);
    chk("t3_no_host_rvalid", 64'(host_rvalid), 64'd0);
    chk("t3_no_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    cyc();

    // 4: cpu read then host read back to back
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h40;
    cyc();
    idle(); host_req = 1; host_addr = 64'h48; mem_rdata = 64'hAAAA;
    @(negedge clk);
    chk("t4_host_gnt", 64'(host_gnt), 64'd1);
    chk("t4_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t4_cpu_rdata", cpu_rdata, 64'hAAAA);
    chk("t4_host_rvalid_early", 64'(host_rvalid), 64'd0);
    cyc();
    idle(); mem_rdata = 64'hBBBB;
    @(negedge clk);
    chk("t4_host_rvalid", 64'(host_rvalid), 64'd1);
    chk("t4_host_rdata", host_rdata, 64'hBBBB);
    chk("t4_cpu_rvalid_off", 64'(cpu_rvalid), 64'd0);
    chk("t4_cpu_rdata_zero", cpu_rdata, 64'd0);
    cyc();

    // 5: host read granted, reset next cycle discards it
    host_req = 1; host_addr = 64'h50;
    @(negedge clk);
    chk("t5_host_gnt", 64'(host_gnt), 64'd1);
    cyc();
    idle(); rst = 1; mem_rdata = 64'hCCCC;
    @(negedge clk);
    chk("t5_rvalid_in_rst", 64'(host_rvalid), 64'd0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t5_rvalid_after", 64'(host_rvalid), 64'd0);
    chk("t5_host_rdata", host_rdata, 64'd0);
    cyc();

    // 5b: reset clears a partly built starvation count
    cpu_req = 1; cpu_addr = 64'h60; host_req = 1; host_addr = 64'h68;
    cyc(); cyc(); cyc();           // count now 3
    rst = 1; cyc(); rst = 0;       // count back to 0
    contend(4, "t5b");
    cyc();
    idle(); cyc();

    // 6: host drops at count 3, then must wait a full 4 again
    cpu_req = 1; cpu_addr = 64'h70; host_req = 1; host_addr = 64'h78;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_pre_host_gnt", 64'(host_gnt), 64'd0);
      cyc();
    end
    host_req = 0;
    @(negedge clk);
    chk("t6_drop_host_gnt", 64'(host_gnt), 64'd0);
    chk("t6_drop_cpu_gnt", 64'(cpu_gnt), 64'd1);
    cyc();
    host_req = 1;
    contend(4, "t6");
    cyc();
    idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop in case anything above stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
